// File: rtl/bus_port_pkg.sv
// Purpose: shared defaults and packet type for the bus port adapter and its bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_port_pkg;

    localparam int pckg_sz_dflt   = 16;
    localparam int deep_fifo_dflt = 8;

    typedef logic [pckg_sz_dflt-1:0] pkt_t;

    // Occupancy counters need one extra bit so a full queue (count == depth)
    // is distinguishable from an empty one.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bus_port_adapter_if.sv
// Purpose: agent/bus-side signal bundle of one bus port adapter.
// Latency: n/a (wiring only).
// Backpressure: n/a; the adapter drives status, the environment drives requests.
// Ports: slave = adapter side, master = agent + bus generator/arbiter side.
interface bus_port_adapter_if #(
    parameter int pckg_sz   = bus_port_pkg::pckg_sz_dflt,
    parameter int deep_fifo = bus_port_pkg::deep_fifo_dflt
);
    localparam int CW = bus_port_pkg::cnt_w(deep_fifo);

    // agent -> TX queue
    logic               tx_push;
    logic [pckg_sz-1:0] tx_data;
    logic               tx_full;
    logic [CW-1:0]      tx_count;
    // TX queue -> bus
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    // bus -> RX queue
    logic               push;
    logic [pckg_sz-1:0] D_push;
    // RX queue -> agent
    logic               rx_pop;
    logic               rx_valid;
    logic [pckg_sz-1:0] rx_data;
    logic [CW-1:0]      rx_count;
    // status
    logic               clr_sts;
    logic               tx_ovf;
    logic               rx_ovf;
    logic               pop_udf;

    modport slave (
        input  tx_push, tx_data, pop, push, D_push, rx_pop, clr_sts,
        output tx_full, tx_count, pndng, D_pop, rx_valid, rx_data, rx_count,
               tx_ovf, rx_ovf, pop_udf
    );

    modport master (
        output tx_push, tx_data, pop, push, D_push, rx_pop, clr_sts,
        input  tx_full, tx_count, pndng, D_pop, rx_valid, rx_data, rx_count,
               tx_ovf, rx_ovf, pop_udf
    );

endinterface

// File: rtl/sync_fwft_fifo.sv
// Purpose: single-clock show-ahead FIFO with per-cycle overflow/underflow events.
// Latency: write visible one cycle after the write edge; head shown with no read latency.
// Backpressure: write while full is dropped (ovf) unless a read frees the slot in the same cycle.
// Ports: wr/wdata write side; rd/rdata/empty read side; full/count occupancy;
//        ovf/udf are single-cycle event strobes (not sticky).
module sync_fwft_fifo
    import bus_port_pkg::*;
#(
    parameter int width = pckg_sz_dflt,
    parameter int depth = deep_fifo_dflt,
    localparam int CW   = cnt_w(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             rd,
    output logic [width-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             udf
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    // Full/empty come from the counter, so pointers may wrap freely.
    assign empty = (count == '0);
    assign full  = (count == CW'(depth));

    // A read on an empty queue is ignored; a write on a full queue only
    // lands when a read drains the head in the same cycle.
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);

    // Full implies non-empty, so rd alone tells whether the slot is freed.
    assign ovf = wr & full & ~rd;
    assign udf = rd & empty;

    // Forced to zero when empty so stale memory never leaks to the output,
    // including straight after an asynchronous reset.
    assign rdata = empty ? '0 : mem[rptr];

    // Storage is not reset; only pointers and count carry state that matters.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_port_adapter.sv
// Purpose: per-driver port adapter; TX queue agent->bus, RX queue bus->agent, sticky error flags.
// Latency: a push is visible (pndng / rx_valid) one cycle after its edge; heads are show-ahead.
// Backpressure: tx_full/rx_count exposed; writes into a full queue are dropped and flagged.
// Ports: clk, reset (async active-low); bus = bus_port_adapter_if.slave carrying
//        tx_push/tx_data/tx_full/tx_count, pndng/D_pop/pop, push/D_push,
//        rx_pop/rx_valid/rx_data/rx_count, clr_sts/tx_ovf/rx_ovf/pop_udf.
module bus_port_adapter
    import bus_port_pkg::*;
#(
    parameter int pckg_sz   = pckg_sz_dflt,
    parameter int deep_fifo = deep_fifo_dflt
) (
    input  logic                clk,
    input  logic                reset,
    bus_port_adapter_if.slave   bus
);

    logic tx_empty;
    logic tx_ovf_evt;
    logic tx_udf_evt;
    logic rx_empty;
    logic rx_ovf_evt;
    // RX full is already visible through rx_count, and an empty rx_pop is
    // deliberately not an error, so these two strobes go nowhere.
    logic rx_full_unused;
    logic rx_udf_unused;

    sync_fwft_fifo #(
        .width (pckg_sz),
        .depth (deep_fifo)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.tx_push),
        .wdata (bus.tx_data),
        .rd    (bus.pop),
        .rdata (bus.D_pop),
        .empty (tx_empty),
        .full  (bus.tx_full),
        .count (bus.tx_count),
        .ovf   (tx_ovf_evt),
        .udf   (tx_udf_evt)
    );

    sync_fwft_fifo #(
        .width (pckg_sz),
        .depth (deep_fifo)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.push),
        .wdata (bus.D_push),
        .rd    (bus.rx_pop),
        .rdata (bus.rx_data),
        .empty (rx_empty),
        .full  (rx_full_unused),
        .count (bus.rx_count),
        .ovf   (rx_ovf_evt),
        .udf   (rx_udf_unused)
    );

    assign bus.pndng    = ~tx_empty;
    assign bus.rx_valid = ~rx_empty;

    // Sticky flags are set-dominant: an event coinciding with clr_sts wins,
    // so no error can slip past a software clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.tx_ovf  <= 1'b0;
            bus.rx_ovf  <= 1'b0;
            bus.pop_udf <= 1'b0;
        end else begin
            bus.tx_ovf  <= tx_ovf_evt | (bus.tx_ovf  & ~bus.clr_sts);
            bus.rx_ovf  <= rx_ovf_evt | (bus.rx_ovf  & ~bus.clr_sts);
            bus.pop_udf <= tx_udf_evt | (bus.pop_udf & ~bus.clr_sts);
        end
    end

endmodule

// File: tb/tb_bus_port_adapter.sv
// Purpose: scoreboard bench for bus_port_adapter (directed plan, then randomized traffic).
// Latency: model queues gain entries at the write edge and are consumed at observed pops.
// Backpressure: model drops writes into a full queue unless a pop frees a slot that cycle.
module tb_bus_port_adapter;
    import bus_port_pkg::*;

    localparam int PCKG_SZ   = pckg_sz_dflt;
    localparam int DEEP_FIFO = deep_fifo_dflt;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bus_port_adapter_if #(.pckg_sz(PCKG_SZ), .deep_fifo(DEEP_FIFO)) bus ();

    bus_port_adapter #(
        .pckg_sz   (PCKG_SZ),
        .deep_fifo (DEEP_FIFO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues of expected packets plus expected flags.
    pkt_t txq[$];
    pkt_t rxq[$];
    bit   tx_ovf_e, rx_ovf_e, pop_udf_e;
    int   tx_pops, tx_pops_seen;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the active edge: writes land in the queues, sticky flags
    // follow set-dominant semantics. Pops were already removed by the monitor,
    // so a full queue with a same-cycle pop has room here.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            txq.delete();
            rxq.delete();
            tx_ovf_e     <= 1'b0;
            rx_ovf_e     <= 1'b0;
            pop_udf_e    <= 1'b0;
            tx_pops_seen <= tx_pops;
        end else begin
            tx_ovf_e  <= (bus.tx_push && txq.size() >= DEEP_FIFO) | (tx_ovf_e & ~bus.clr_sts);
            rx_ovf_e  <= (bus.push && rxq.size() >= DEEP_FIFO)    | (rx_ovf_e & ~bus.clr_sts);
            pop_udf_e <= (bus.pop && tx_pops == tx_pops_seen)     | (pop_udf_e & ~bus.clr_sts);
            tx_pops_seen <= tx_pops;
            if (bus.tx_push && txq.size() < DEEP_FIFO) txq.push_back(bus.tx_data);
            if (bus.push && rxq.size() < DEEP_FIFO)    rxq.push_back(bus.D_push);
        end
    end

    // Monitor: samples on the falling edge. Status is compared every cycle;
    // packet data is popped from the scoreboard whenever a consumer takes one.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            #1;
            chk("rst_pndng",    32'(bus.pndng),    32'd0);
            chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
            chk("rst_tx_count", 32'(bus.tx_count), 32'd0);
            chk("rst_rx_count", 32'(bus.rx_count), 32'd0);
            chk("rst_tx_full",  32'(bus.tx_full),  32'd0);
            chk("rst_D_pop",    32'(bus.D_pop),    32'd0);
            chk("rst_rx_data",  32'(bus.rx_data),  32'd0);
            chk("rst_flags",    {29'd0, bus.tx_ovf, bus.rx_ovf, bus.pop_udf}, 32'd0);
        end else begin
            chk("tx_count", 32'(bus.tx_count), 32'(txq.size()));
            chk("pndng",    32'(bus.pndng),    32'(txq.size() != 0));
            chk("tx_full",  32'(bus.tx_full),  32'(txq.size() == DEEP_FIFO));
            chk("rx_count", 32'(bus.rx_count), 32'(rxq.size()));
            chk("rx_valid", 32'(bus.rx_valid), 32'(rxq.size() != 0));
            chk("tx_ovf",   32'(bus.tx_ovf),   32'(tx_ovf_e));
            chk("rx_ovf",   32'(bus.rx_ovf),   32'(rx_ovf_e));
            chk("pop_udf",  32'(bus.pop_udf),  32'(pop_udf_e));
            if (txq.size() == 0) chk("D_pop_empty",   32'(bus.D_pop),   32'd0);
            if (rxq.size() == 0) chk("rx_data_empty", 32'(bus.rx_data), 32'd0);
            if (bus.pop && txq.size() != 0) begin
                chk("D_pop", 32'(bus.D_pop), 32'(txq[0]));
                void'(txq.pop_front());
                tx_pops <= tx_pops + 1;
            end
            if (bus.rx_pop && rxq.size() != 0) begin
                chk("rx_data", 32'(bus.rx_data), 32'(rxq[0]));
                void'(rxq.pop_front());
            end
        end
    end

    // Drive one cycle of stimulus, held across the next rising edge.
    task automatic cyc(input bit tp, input pkt_t td, input bit p,
                       input bit ps, input pkt_t dp, input bit rp, input bit clr);
        bus.tx_push = tp;
        bus.tx_data = td;
        bus.pop     = p;
        bus.push    = ps;
        bus.D_push  = dp;
        bus.rx_pop  = rp;
        bus.clr_sts = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, '0, 0, 0);
    endtask

    int pw, pp, ps, pr;

    initial begin
        tx_pops = 0;
        bus.tx_push = 0; bus.tx_data = '0; bus.pop = 0; bus.push = 0;
        bus.D_push = '0; bus.rx_pop = 0; bus.clr_sts = 0;
        #1 reset = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        idle(1);

        // 1: two pushes, two pops
        cyc(1, 16'h0014, 0, 0, '0, 0, 0);
        cyc(1, 16'h000A, 0, 0, '0, 0, 0);
        cyc(0, '0, 1, 0, '0, 0, 0);
        cyc(0, '0, 1, 0, '0, 0, 0);
        idle(1);

        // 2: nine pushes into an 8-deep queue, drain across the wrap, clear
        for (int i = 0; i < 9; i++) cyc(1, pkt_t'(16'h0100 + i), 0, 0, '0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, '0, 0, 0);
        cyc(0, '0, 0, 0, '0, 0, 1);
        idle(1);

        // 3: full queue, simultaneous push + pop
        for (int i = 0; i < 8; i++) cyc(1, pkt_t'(16'h0200 + i), 0, 0, '0, 0, 0);
        cyc(1, 16'h00AA, 1, 0, '0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, '0, 0, 0);
        idle(1);

        // 4: pop on empty coinciding with a push
        cyc(1, 16'h0033, 1, 0, '0, 0, 0);
        idle(1);
        cyc(0, '0, 1, 0, '0, 0, 1);
        idle(1);

        // 5: RX fill past full, then drain
        for (int i = 1; i <= 9; i++) cyc(0, '0, 0, 1, pkt_t'(16'h0500 + i), 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, '0, 0, 0, '0, 1, 0);
        idle(1);

        // 6: asynchronous reset with both queues partly full
        for (int i = 0; i < 3; i++) cyc(1, pkt_t'(16'h0600 + i), 0, 1, pkt_t'(16'h0700 + i), 0, 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        cyc(1, 16'h0777, 0, 1, 16'h0888, 0, 0);
        cyc(1, 16'h0778, 0, 0, '0, 0, 0);
        cyc(0, '0, 1, 0, '0, 1, 0);
        cyc(0, '0, 1, 0, '0, 1, 0);
        idle(1);

        // Randomized traffic in phases biased towards filling, draining, mixed, saturated
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin pw = 70; pp = 20; ps = 70; pr = 20; end
                1:       begin pw = 30; pp = 70; ps = 30; pr = 70; end
                2:       begin pw = 50; pp = 50; ps = 50; pr = 50; end
                default: begin pw = 90; pp = 90; ps = 90; pr = 90; end
            endcase
            for (int i = 0; i < 200; i++) begin
                cyc($urandom_range(99) < pw, pkt_t'($urandom), $urandom_range(99) < pp,
                    $urandom_range(99) < ps, pkt_t'($urandom), $urandom_range(99) < pr,
                    $urandom_range(99) < 4);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
